// File: rtl/memory_unit_if.sv
// Sequencer-to-memory bus: request strobes, address/data in, and read data, status and completion out.
// The master modport is the control sequencer/datapath side and the slave modport is memory_unit.
interface memory_unit_if;
    logic        Read;
    logic        Write;
    logic [31:0] MAR_in;
    logic [31:0] MDR_in;
    logic [31:0] Mdata_out;
    logic        MDRead;
    logic        mem_done;
    logic        busy;
    logic        addr_err;

    modport master (
        output Read, Write, MAR_in, MDR_in,
        input  Mdata_out, MDRead, mem_done, busy, addr_err
    );

    modport slave (
        input  Read, Write, MAR_in, MDR_in,
        output Mdata_out, MDRead, mem_done, busy, addr_err
    );
endinterface

// File: rtl/memory_unit.sv
// Word memory with wait states: a request accepted in IDLE completes with a one-cycle DONE pulse WAIT_CYCLES+2 cycles later.
// There is no queueing: strobes are ignored while busy, and the sequencer must hold off until busy drops.
module memory_unit #(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    memory_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The counter is preloaded with WAIT_CYCLES-1 so that WAIT ends when it reads zero.
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        is_wr_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        oor;
    logic [ADDR_W-1:0] idx;

    logic [31:0] mem [DEPTH];

    assign idx = addr_q[ADDR_W-1:0];
    assign oor = |addr_q[31:ADDR_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Read || bus.Write) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write wins when both strobes are high at acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            is_wr_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.MAR_in;
            data_q  <= bus.MDR_in;
            is_wr_q <= bus.Write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'd0;
        end else if (state_q == ACCESS && !is_wr_q) begin
            rdata_q <= oor ? 32'd0 : mem[idx];
        end
    end

    // Array is never reset; an aborted write never reaches ACCESS because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && is_wr_q && !oor) begin
            mem[idx] <= data_q;
        end
    end

    assign bus.Mdata_out = rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_done  = (state_q == DONE);
    assign bus.MDRead    = (state_q == DONE) && !is_wr_q;
    assign bus.addr_err  = (state_q == DONE) && oor;

endmodule
